// File: rtl/unified_mem_if.sv
// Core-to-memory bus for the unified instruction/data memory model.
// The core drives commands as master; the memory answers with tags as slave.
`timescale 1ns/1ps
interface unified_mem_if #(
    parameter int XLEN = 32
);
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [1:0]      proc2mem_size;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );
    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );
endinterface

// File: rtl/unified_mem.sv
// Tagged fixed-latency unified memory model: accepts one load/store per cycle,
// writes stores at accept and returns every tag MEM_LATENCY edges later.
`timescale 1ns/1ps
module unified_mem #(
    parameter int MEM_LINES   = 8192,
    parameter int MEM_LATENCY = 4,
    parameter int NUM_TAGS    = 15,
    parameter int XLEN        = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    unified_mem_if.slave mem
);
    typedef enum logic [1:0] {CMD_NONE, CMD_LOAD, CMD_STORE, CMD_RSVD} cmd_e;

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [XLEN-4:0] LINES_LIM = (XLEN-3)'(MEM_LINES);

    logic [63:0] unified_memory [0:MEM_LINES-1];

    logic [CNT_W-1:0] cnt      [1:NUM_TAGS];
    logic [63:0]      tag_data [1:NUM_TAGS];

    logic [IDX_W-1:0] line_idx;
    logic [2:0]       off;
    logic             is_load, is_store, in_range, aligned, accept;
    logic [3:0]       free_tag, done_tag;
    logic [63:0]      done_data, rd_line, wdata, wmask;
    logic [7:0]       bmask;

    assign line_idx = mem.proc2mem_addr[3 +: IDX_W];
    assign off      = mem.proc2mem_addr[2:0];
    assign is_load  = cmd_e'(mem.proc2mem_command) == CMD_LOAD;
    assign is_store = cmd_e'(mem.proc2mem_command) == CMD_STORE;
    assign in_range = mem.proc2mem_addr[XLEN-1:3] < LINES_LIM;
    assign rd_line  = unified_memory[line_idx];
    assign wdata    = mem.proc2mem_data << {off, 3'b000};

    always_comb begin
        aligned = 1'b1;
        bmask   = 8'h01;
        case (mem.proc2mem_size)
            2'd1: begin aligned = (off[0]   == 1'b0);  bmask = 8'h03; end
            2'd2: begin aligned = (off[1:0] == 2'b00); bmask = 8'h0F; end
            2'd3: begin aligned = (off      == 3'b000); bmask = 8'hFF; end
            default: ;
        endcase
        bmask = bmask << off;
        for (int b = 0; b < 8; b++) wmask[8*b +: 8] = {8{bmask[b]}};
    end

    // Lowest free tag wins; a tag finishing this edge still counts as busy,
    // so it cannot be handed out again in the same cycle.
    always_comb begin
        free_tag  = '0;
        done_tag  = '0;
        done_data = '0;
        for (int t = NUM_TAGS; t >= 1; t--)
            if (cnt[t] == '0) free_tag = 4'(t);
        for (int t = 1; t <= NUM_TAGS; t++)
            if (cnt[t] == CNT_W'(1)) begin
                done_tag  = 4'(t);
                done_data = tag_data[t];
            end
    end

    assign accept = reset_n && (is_load || is_store) && in_range && aligned && (free_tag != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 1; t <= NUM_TAGS; t++) begin
                cnt[t]      <= '0;
                tag_data[t] <= '0;
            end
            mem.mem2proc_response <= '0;
            mem.mem2proc_tag      <= '0;
            mem.mem2proc_data     <= '0;
        end else begin
            for (int t = 1; t <= NUM_TAGS; t++)
                if (cnt[t] != '0) cnt[t] <= cnt[t] - CNT_W'(1);
            if (accept) begin
                cnt[free_tag]      <= CNT_W'(MEM_LATENCY);
                tag_data[free_tag] <= is_load ? rd_line : 64'd0;
            end
            mem.mem2proc_response <= accept ? free_tag : 4'd0;
            mem.mem2proc_tag      <= done_tag;
            mem.mem2proc_data     <= done_data;
        end
    end

    // Backing store is never reset so the bench can preload it while in reset.
    always_ff @(posedge clk) begin
        if (accept && is_store)
            unified_memory[line_idx] <= (unified_memory[line_idx] & ~wmask) | (wdata & wmask);
    end
endmodule

// File: tb/tb_unified_mem.sv
// Directed bench for unified_mem: a default instance (latency 4) and a long
// latency instance (16) used to exhaust all fifteen tags.
`timescale 1ns/1ps
module tb_unified_mem;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0] LINE0   = 64'h1122334455667788;
    localparam logic [63:0] LINE0_W = 64'h1122AB4455667788;
    localparam logic [63:0] XLINE0  = 64'hCAFEF00DDEADBEEF;

    unified_mem_if #(.XLEN(32)) bus();
    unified_mem_if #(.XLEN(32)) xbus();

    unified_mem dut (.clk(clk), .reset_n(reset_n), .mem(bus));
    unified_mem #(.MEM_LATENCY(16)) dut_x (.clk(clk), .reset_n(reset_n), .mem(xbus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
        bus.proc2mem_command = c;
        bus.proc2mem_addr    = a;
        bus.proc2mem_data    = d;
        bus.proc2mem_size    = s;
    endtask

    task automatic xdrive(input logic [1:0] c, input logic [31:0] a);
        xbus.proc2mem_command = c;
        xbus.proc2mem_addr    = a;
        xbus.proc2mem_data    = 64'd0;
        xbus.proc2mem_size    = 2'd3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_tag"}, {60'd0, bus.mem2proc_tag}, 64'd0);
        chk({name, "_data"}, bus.mem2proc_data, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        drive(2'd0, 32'd0, 64'd0, 2'd0);
        xdrive(2'd0, 32'd0);
        dut.unified_memory[0]   = LINE0;
        dut_x.unified_memory[0] = XLINE0;
        tick(); tick(); tick();
        chk("rst_resp", {60'd0, bus.mem2proc_response}, 64'd0);
        chk_idle("rst");
        reset_n = 1'b1;
        tick();
        chk("post_rst_resp", {60'd0, bus.mem2proc_response}, 64'd0);
        chk_idle("post_rst");
        chk("line0_kept", dut.unified_memory[0], LINE0);

        // Plain double load: tag 1, returns four edges after accept.
        drive(2'd1, 32'h0, 64'd0, 2'd3);
        tick();
        chk("ld_resp", {60'd0, bus.mem2proc_response}, 64'd1);
        drive(2'd0, 32'd0, 64'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("ld_wait");
        end
        tick();
        chk("ld_tag", {60'd0, bus.mem2proc_tag}, 64'd1);
        chk("ld_data", bus.mem2proc_data, LINE0);
        tick();
        chk_idle("ld_after");

        // Byte store then load of the same line sees the new byte.
        drive(2'd2, 32'h5, 64'hFFFF_FFFF_FFFF_FFAB, 2'd0);
        tick();
        chk("st_resp", {60'd0, bus.mem2proc_response}, 64'd1);
        drive(2'd1, 32'h0, 64'd0, 2'd3);
        tick();
        chk("st_ld_resp", {60'd0, bus.mem2proc_response}, 64'd2);
        drive(2'd0, 32'd0, 64'd0, 2'd0);
        tick(); chk_idle("st_wait0");
        tick(); chk_idle("st_wait1");
        tick();
        chk("st_tag", {60'd0, bus.mem2proc_tag}, 64'd1);
        chk("st_data", bus.mem2proc_data, 64'd0);
        tick();
        chk("st_ld_tag", {60'd0, bus.mem2proc_tag}, 64'd2);
        chk("st_ld_data", bus.mem2proc_data, LINE0_W);
        chk("st_line", dut.unified_memory[0], LINE0_W);

        // Back-to-back loads at latency 4: tag 1 completing on the fifth
        // accept is still busy there, then reused on the sixth.
        for (int i = 0; i < 6; i++) begin
            drive(2'd1, 32'h8, 64'd0, 2'd3);
            tick();
            chk("b2b_resp", {60'd0, bus.mem2proc_response}, (i < 5) ? 64'(i + 1) : 64'd1);
        end
        drive(2'd0, 32'd0, 64'd0, 2'd0);
        for (int i = 0; i < 6; i++) tick();
        chk_idle("b2b_drained");

        // Rejected requests: out of range, misaligned, reserved command.
        drive(2'd1, 32'h0001_0000, 64'd0, 2'd3);
        tick();
        chk("oor_resp", {60'd0, bus.mem2proc_response}, 64'd0);
        drive(2'd1, 32'h2, 64'd0, 2'd2);
        tick();
        chk("misal_w_resp", {60'd0, bus.mem2proc_response}, 64'd0);
        drive(2'd2, 32'h1, 64'hFFFF, 2'd1);
        tick();
        chk("misal_h_resp", {60'd0, bus.mem2proc_response}, 64'd0);
        drive(2'd3, 32'h0, 64'd0, 2'd3);
        tick();
        chk("rsvd_resp", {60'd0, bus.mem2proc_response}, 64'd0);
        drive(2'd0, 32'd0, 64'd0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_idle("rej_no_tag");
        end
        chk("misal_h_line", dut.unified_memory[0], LINE0_W);

        // Reset two cycles after an accept drops both pending returns.
        drive(2'd1, 32'h0, 64'd0, 2'd3);
        tick();
        chk("pre_rst_resp1", {60'd0, bus.mem2proc_response}, 64'd1);
        tick();
        chk("pre_rst_resp2", {60'd0, bus.mem2proc_response}, 64'd2);
        drive(2'd0, 32'd0, 64'd0, 2'd0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("async_rst_resp", {60'd0, bus.mem2proc_response}, 64'd0);
        chk_idle("async_rst");
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_idle("dropped");
        end
        drive(2'd1, 32'h0, 64'd0, 2'd3);
        tick();
        chk("post_rst_tag1", {60'd0, bus.mem2proc_response}, 64'd1);
        drive(2'd1, 32'h0, 64'd0, 2'd3);
        tick();
        chk("post_rst_tag2", {60'd0, bus.mem2proc_response}, 64'd2);
        drive(2'd0, 32'd0, 64'd0, 2'd0);
        tick(); tick();
        tick();
        chk("post_rst_ret_tag", {60'd0, bus.mem2proc_tag}, 64'd1);
        chk("post_rst_ret_data", bus.mem2proc_data, LINE0_W);
        tick();
        chk("post_rst_ret_tag2", {60'd0, bus.mem2proc_tag}, 64'd2);

        // Tag exhaustion at latency 16: tags 1..15, then rejects until tag 1
        // has completed and been freed.
        for (int i = 0; i < 18; i++) begin
            xdrive(2'd1, 32'h0);
            tick();
            chk("exh_resp", {60'd0, xbus.mem2proc_response},
                (i < 15) ? 64'(i + 1) : ((i == 17) ? 64'd1 : 64'd0));
            if (i == 16) begin
                chk("exh_tag", {60'd0, xbus.mem2proc_tag}, 64'd1);
                chk("exh_data", xbus.mem2proc_data, XLINE0);
            end
        end
        xdrive(2'd0, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
